// File: rtl/sk6812_pkg.sv
// Shared types for the SK6812 strip sequencer: FSM state encoding and colour layout.
package sk6812_pkg;

   localparam int COLOUR_W = 32;

   typedef enum logic [3:0] {
      IDLE,
      READ,
      LOAD,
      STRB,
      WAIT_HI,
      WAIT_LO,
      LATCH,
      WAIT_HI2,
      WAIT_LO2,
      DONE
   } seq_state_t;

   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
      logic [7:0] w;
   } colour_t;

endpackage

// File: rtl/sk6812_frame_buffer.sv
// One-write/one-read colour RAM with a registered read port (read-before-write on collision).
module sk6812_frame_buffer
   import sk6812_pkg::*;
#(
   parameter int NUM_LEDS = 16,
   parameter int ADDR_W   = $clog2(NUM_LEDS)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  colour_t           wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output colour_t           rd_data
);

   colour_t mem [NUM_LEDS];

   // No reset on purpose: contents survive a sequencer reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/sk6812_strip_sequencer.sv
// Streams buffered RGBW colours to the single-LED SK6812 driver, then latches the strip.
// Optional continuous refresh is enabled by defining SK6812_SEQ_LOOP_EN (adds i_loop).
module sk6812_strip_sequencer
   import sk6812_pkg::*;
#(
   parameter int NUM_LEDS = 16,
   parameter int ADDR_W   = $clog2(NUM_LEDS),
   parameter int CNT_W    = $clog2(NUM_LEDS + 1)
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_wr_en,
   input  logic [ADDR_W-1:0]   i_wr_addr,
   input  logic [COLOUR_W-1:0] i_wr_data,
   input  logic                i_start,
   input  logic [CNT_W-1:0]    i_count,
`ifdef SK6812_SEQ_LOOP_EN
   input  logic                i_loop,
`endif
   output logic                o_busy,
   output logic                o_done,
   output logic                o_led_strb,
   output logic [COLOUR_W-1:0] o_led_color,
   output logic                o_reset_strb,
   input  logic                i_led_busy
);

   localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(NUM_LEDS);

   seq_state_t       state_reg, state_next;
   logic [CNT_W-1:0] index_reg, index_next;
   logic [CNT_W-1:0] count_reg, count_next;
   colour_t          color_reg, color_next;
   colour_t          rd_data;
   logic [CNT_W-1:0] start_count;

   sk6812_frame_buffer #(
      .NUM_LEDS (NUM_LEDS),
      .ADDR_W   (ADDR_W)
   ) u_buffer (
      .clk     (i_clk),
      .wr_en   (i_wr_en),
      .wr_addr (i_wr_addr),
      .wr_data (colour_t'(i_wr_data)),
      .rd_addr (index_reg[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

   assign start_count = (i_count > MAX_COUNT) ? MAX_COUNT : i_count;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg <= IDLE;
         index_reg <= '0;
         count_reg <= '0;
         color_reg <= '0;
      end else begin
         state_reg <= state_next;
         index_reg <= index_next;
         count_reg <= count_next;
         color_reg <= color_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      index_next = index_reg;
      count_next = count_reg;
      color_next = color_reg;
      unique case (state_reg)
         IDLE: begin
            if (i_start) begin
               count_next = start_count;
               index_next = '0;
               // An empty frame still latches the strip.
               state_next = (start_count == '0) ? LATCH : READ;
            end
         end
         READ:    state_next = LOAD;
         LOAD: begin
            color_next = rd_data;
            state_next = STRB;
         end
         STRB:    state_next = WAIT_HI;
         WAIT_HI: if (i_led_busy)  state_next = WAIT_LO;
         WAIT_LO: begin
            if (!i_led_busy) begin
               index_next = index_reg + 1'b1;
               state_next = (index_next == count_reg) ? LATCH : READ;
            end
         end
         LATCH:    state_next = WAIT_HI2;
         WAIT_HI2: if (i_led_busy)  state_next = WAIT_LO2;
         WAIT_LO2: if (!i_led_busy) state_next = DONE;
         DONE: begin
`ifdef SK6812_SEQ_LOOP_EN
            if (i_loop) begin
               index_next = '0;
               state_next = (count_reg == '0) ? LATCH : READ;
            end else begin
               state_next = IDLE;
            end
`else
            state_next = IDLE;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs decode straight from the state register so an async reset clears them at once.
   assign o_busy       = (state_reg != IDLE);
   assign o_done       = (state_reg == DONE);
   assign o_led_strb   = (state_reg == STRB);
   assign o_reset_strb = (state_reg == LATCH);
   assign o_led_color  = color_reg;

endmodule

// File: tb/tb_sk6812_strip_sequencer.sv
// Self-checking bench for sk6812_strip_sequencer with a busy-handshake driver model and colour scoreboard.
module tb_sk6812_strip_sequencer;

   localparam int NUM_LEDS = 16;
   localparam int ADDR_W   = 4;
   localparam int CNT_W    = 5;

   logic              i_clk;
   logic              i_reset_n;
   logic              i_wr_en;
   logic [ADDR_W-1:0] i_wr_addr;
   logic [31:0]       i_wr_data;
   logic              i_start;
   logic [CNT_W-1:0]  i_count;
`ifdef SK6812_SEQ_LOOP_EN
   logic              i_loop;
`endif
   logic              o_busy;
   logic              o_done;
   logic              o_led_strb;
   logic [31:0]       o_led_color;
   logic              o_reset_strb;
   logic              i_led_busy;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q [$];
   int led_cnt, rst_cnt, done_cnt, busy_gaps;
   bit in_frame;
   int drv_delay, drv_hold, drv_phase, drv_cnt;

   sk6812_strip_sequencer #(
      .NUM_LEDS (NUM_LEDS),
      .ADDR_W   (ADDR_W),
      .CNT_W    (CNT_W)
   ) dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_wr_en      (i_wr_en),
      .i_wr_addr    (i_wr_addr),
      .i_wr_data    (i_wr_data),
      .i_start      (i_start),
      .i_count      (i_count),
`ifdef SK6812_SEQ_LOOP_EN
      .i_loop       (i_loop),
`endif
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_led_strb   (o_led_strb),
      .o_led_color  (o_led_color),
      .o_reset_strb (o_reset_strb),
      .i_led_busy   (i_led_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Monitor/scoreboard first, then the driver model, in one process to avoid ordering races.
   always @(negedge i_clk) begin
      logic [31:0] exp;
      if (i_reset_n) begin
         if (o_led_strb) begin
            led_cnt++;
            $display("strobe %0d colour=%08h", led_cnt, o_led_color);
            checks++;
            if (drv_phase != 0) begin
               errors++;
               $display("FAIL strb_while_driver_busy: got strobe, required no strobe until busy falls");
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe: got colour %08h, required no strobe", o_led_color);
            end else begin
               exp = exp_q.pop_front();
               if (o_led_color !== exp) begin
                  errors++;
                  $display("FAIL led_color: got %08h, required %08h", o_led_color, exp);
               end
            end
         end
         if (o_reset_strb) begin
            rst_cnt++;
            $display("reset strobe %0d", rst_cnt);
         end
         if (o_done) begin
            done_cnt++;
            $display("done %0d", done_cnt);
         end
         if (in_frame && !o_busy) busy_gaps++;
      end

      if (!i_reset_n) begin
         i_led_busy = 1'b0;
         drv_phase  = 0;
         drv_cnt    = 0;
      end else begin
         case (drv_phase)
            0: if (o_led_strb || o_reset_strb) begin
               if (drv_delay == 0) begin
                  i_led_busy = 1'b1;
                  drv_phase  = 2;
                  drv_cnt    = drv_hold;
               end else begin
                  drv_phase = 1;
                  drv_cnt   = drv_delay;
               end
            end
            1: begin
               drv_cnt--;
               if (drv_cnt == 0) begin
                  i_led_busy = 1'b1;
                  drv_phase  = 2;
                  drv_cnt    = drv_hold;
               end
            end
            default: begin
               drv_cnt--;
               if (drv_cnt == 0) begin
                  i_led_busy = 1'b0;
                  drv_phase  = 0;
               end
            end
         endcase
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic write_buf(input int addr, input logic [31:0] data);
      i_wr_en   = 1'b1;
      i_wr_addr = ADDR_W'(addr);
      i_wr_data = data;
      @(negedge i_clk);
      i_wr_en   = 1'b0;
   endtask

   task automatic clear_counts();
      led_cnt   = 0;
      rst_cnt   = 0;
      done_cnt  = 0;
      busy_gaps = 0;
      exp_q.delete();
   endtask

   task automatic start_frame(input int cnt);
      i_count = CNT_W'(cnt);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start  = 1'b0;
      in_frame = 1'b1;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!o_done && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      checks++;
      if (!o_done) begin
         errors++;
         $display("FAIL %s_timeout: no o_done after %0d cycles, required o_done", name, budget);
      end
      in_frame = 1'b0;
      @(negedge i_clk);
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy_after_done: got %b, required 0", name, o_busy);
      end
   endtask

   task automatic check_frame(input string name, input int leds);
      checks++;
      if (led_cnt != leds) begin
         errors++;
         $display("FAIL %s_led_strobes: got %0d, required %0d", name, led_cnt, leds);
      end
      checks++;
      if (rst_cnt != 1 || done_cnt != 1) begin
         errors++;
         $display("FAIL %s_latch_done: got reset=%0d done=%0d, required 1 and 1", name, rst_cnt, done_cnt);
      end
      checks++;
      if (busy_gaps != 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_busy_or_leftover: got gaps=%0d pending=%0d, required 0 and 0",
                  name, busy_gaps, exp_q.size());
      end
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0;
      tick(3);
      checks++;
      if ({o_busy, o_done, o_led_strb, o_reset_strb} !== 4'b0 || o_led_color !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b strb=%b rst=%b colour=%08h, required all 0",
                  o_busy, o_done, o_led_strb, o_reset_strb, o_led_color);
      end
      i_reset_n = 1'b1;
      tick(2);
   endtask

   task automatic test_basic();
      write_buf(0, 32'h11223344);
      write_buf(1, 32'hAABBCCDD);
      clear_counts();
      exp_q.push_back(32'h11223344);
      exp_q.push_back(32'hAABBCCDD);
      start_frame(2);
      wait_done("basic", 1000);
      check_frame("basic", 2);
   endtask

   task automatic test_zero_count();
      clear_counts();
      start_frame(0);
      wait_done("zero", 500);
      check_frame("zero", 0);
   endtask

   task automatic test_clamp_and_ignore();
      for (int i = 0; i < NUM_LEDS; i++) write_buf(i, 32'h5A000000 ^ (i * 32'h01030507));
      clear_counts();
      for (int i = 0; i < NUM_LEDS; i++) exp_q.push_back(32'h5A000000 ^ (i * 32'h01030507));
      start_frame(NUM_LEDS + 5);
      tick(40);
      i_count = CNT_W'(1);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      wait_done("clamp", 4000);
      check_frame("clamp", NUM_LEDS);
   endtask

   task automatic test_late_busy();
      drv_delay = 3;
      drv_hold  = 4;
      write_buf(0, 32'h01020304);
      write_buf(1, 32'hF0E0D0C0);
      clear_counts();
      exp_q.push_back(32'h01020304);
      exp_q.push_back(32'hF0E0D0C0);
      start_frame(2);
      wait_done("late", 1000);
      check_frame("late", 2);
      drv_delay = 0;
      drv_hold  = 10;
   endtask

   task automatic test_rewrite_in_flight();
      int n = 0;
      write_buf(0, 32'hA0A0A0A0);
      write_buf(1, 32'hB1B1B1B1);
      write_buf(2, 32'hC2C2C2C2);
      clear_counts();
      exp_q.push_back(32'hA0A0A0A0);
      exp_q.push_back(32'hB1B1B1B1);
      exp_q.push_back(32'hD3D3D3D3);
      start_frame(3);
      while (led_cnt < 1 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      write_buf(2, 32'hD3D3D3D3);
      write_buf(0, 32'hEEEEEEEE);
      wait_done("rewrite", 1000);
      check_frame("rewrite", 3);
   endtask

   task automatic test_midframe_reset();
      int n = 0;
      write_buf(0, 32'h0BADF00D);
      write_buf(1, 32'hCAFEBABE);
      clear_counts();
      exp_q.push_back(32'h0BADF00D);
      exp_q.push_back(32'hCAFEBABE);
      start_frame(2);
      while (led_cnt < 2 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      tick(3);
      i_reset_n = 1'b0;
      #1;
      checks++;
      if ({o_busy, o_led_strb, o_reset_strb} !== 3'b0) begin
         errors++;
         $display("FAIL midreset_outputs: got busy=%b strb=%b rst=%b, required 0 0 0",
                  o_busy, o_led_strb, o_reset_strb);
      end
      in_frame = 1'b0;
      tick(2);
      i_reset_n = 1'b1;
      tick(1);
      clear_counts();
      exp_q.push_back(32'h0BADF00D);
      start_frame(1);
      wait_done("after_reset", 500);
      check_frame("after_reset", 1);
   endtask

`ifdef SK6812_SEQ_LOOP_EN
   task automatic test_loop();
      int n = 0;
      write_buf(0, 32'h12345678);
      clear_counts();
      repeat (4) exp_q.push_back(32'h12345678);
      i_loop = 1'b1;
      start_frame(1);
      while (done_cnt < 3 && n < 1000) begin
         @(negedge i_clk);
         n++;
      end
      tick(2);
      i_loop = 1'b0;
      wait_done("loop", 500);
      checks++;
      if (led_cnt != 4 || rst_cnt != 4 || done_cnt != 4) begin
         errors++;
         $display("FAIL loop_frames: got strb=%0d rst=%0d done=%0d, required 4 4 4",
                  led_cnt, rst_cnt, done_cnt);
      end
      checks++;
      if (busy_gaps != 0) begin
         errors++;
         $display("FAIL loop_busy_gaps: got %0d, required 0", busy_gaps);
      end
   endtask
`endif

   initial begin
      i_reset_n = 1'b0;
      i_wr_en   = 1'b0;
      i_wr_addr = '0;
      i_wr_data = '0;
      i_start   = 1'b0;
      i_count   = '0;
`ifdef SK6812_SEQ_LOOP_EN
      i_loop    = 1'b0;
`endif
      drv_delay = 0;
      drv_hold  = 10;
      in_frame  = 1'b0;
      clear_counts();
      @(negedge i_clk);
      test_reset();
      test_basic();
      test_zero_count();
      test_clamp_and_ignore();
      test_late_busy();
      test_rewrite_in_flight();
      test_midframe_reset();
`ifdef SK6812_SEQ_LOOP_EN
      test_loop();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
